// File: rtl/weight_cache_reader.sv
// Weight cache read streamer: replays a Matrix_Row x Matrix_Col weight matrix
// Repeat_Times times from a 1-cycle-latency cache RAM onto a valid/ready stream.
module weight_cache_reader #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 20,
  parameter int CFG_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CFG_W-1:0]  Matrix_Row,
  input  logic [CFG_W-1:0]  Matrix_Col,
  input  logic [CFG_W-1:0]  Repeat_Times,
  output logic              Cache_Rd_En,
  output logic [ADDR_W-1:0] Cache_Rd_Addr,
  input  logic [DATA_W-1:0] Cache_Rd_Data,
  output logic [DATA_W-1:0] mData,
  output logic              mValid,
  input  logic              mReady,
  output logic              mPass_Last,
  output logic              mLast,
  output logic              busy,
  output logic              done,
  output logic [1:0]        dbg_state
);

  // Stream handshake: a beat moves when mValid && mReady; while mValid is high
  // and mReady low, mData/mPass_Last/mLast are held unchanged.

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_t;

  localparam int ENT_W = DATA_W + 2;

  state_t             state_q, state_d;
  logic [31:0]        wpp_q, wpp_d;
  logic [CFG_W-1:0]   rep_q, rep_d;
  logic [31:0]        idx_q, idx_d;
  logic [CFG_W-1:0]   pass_q, pass_d;
  logic               inf_q, inf_pl_q, inf_last_q;
  logic [ENT_W-1:0]   mem_q [2];
  logic               wr_ptr_q, rd_ptr_q;
  logic [1:0]         cnt_q;
  logic               done_q;

  logic               fifo_empty, valid, hs, push, pop, room, rd_en;
  logic               end_of_pass, final_pass, degenerate;
  logic [ENT_W-1:0]   head, inf_entry;

  assign inf_entry  = {inf_last_q, inf_pl_q, Cache_Rd_Data};
  assign fifo_empty = (cnt_q == 2'd0);
  // With an empty buffer the returning read is presented directly, giving
  // mValid one cycle after the read strobe.
  assign head       = fifo_empty ? inf_entry : mem_q[rd_ptr_q];
  assign valid      = !fifo_empty || inf_q;
  assign hs         = valid && mReady;
  assign pop        = hs && !fifo_empty;
  assign push       = inf_q && !(hs && fifo_empty);

  assign end_of_pass = (idx_q == wpp_q - 32'd1);
  assign final_pass  = (pass_q == rep_q - CFG_W'(1));
  assign degenerate  = (Matrix_Row == '0) || (Matrix_Col < CFG_W'(8)) ||
                       (Repeat_Times == '0);
  // occupancy + in_flight - handshake < 2, rearranged to stay unsigned
  assign room  = ({1'b0, cnt_q} + {2'b0, inf_q}) < (3'd2 + {2'b0, hs});
  assign rd_en = (state_q == S_RUN) && room;

  always_comb begin
    state_d = state_q;
    wpp_d   = wpp_q;
    rep_d   = rep_q;
    idx_d   = idx_q;
    pass_d  = pass_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          wpp_d   = 32'(Matrix_Row) * 32'(Matrix_Col >> 3);
          rep_d   = Repeat_Times;
          idx_d   = '0;
          pass_d  = '0;
          state_d = degenerate ? S_FIN : S_RUN;
        end
      end
      S_RUN: begin
        if (rd_en) begin
          if (end_of_pass) begin
            idx_d  = '0;
            pass_d = pass_q + CFG_W'(1);
            if (final_pass) state_d = S_DRAIN;
          end else begin
            idx_d = idx_q + 32'd1;
          end
        end
      end
      S_DRAIN: begin
        if ((hs && head[ENT_W-1]) || (fifo_empty && !inf_q)) state_d = S_FIN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wpp_q      <= '0;
      rep_q      <= '0;
      idx_q      <= '0;
      pass_q     <= '0;
      inf_q      <= 1'b0;
      inf_pl_q   <= 1'b0;
      inf_last_q <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      wpp_q      <= wpp_d;
      rep_q      <= rep_d;
      idx_q      <= idx_d;
      pass_q     <= pass_d;
      // Sideband flags travel with the read so they line up with its data.
      inf_q      <= rd_en;
      inf_pl_q   <= rd_en && end_of_pass;
      inf_last_q <= rd_en && end_of_pass && final_pass;
      done_q     <= (state_q == S_FIN);
      if (push) begin
        mem_q[wr_ptr_q] <= inf_entry;
        wr_ptr_q        <= !wr_ptr_q;
      end
      if (pop) rd_ptr_q <= !rd_ptr_q;
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  assign Cache_Rd_En   = rd_en;
  assign Cache_Rd_Addr = rd_en ? idx_q[ADDR_W-1:0] : '0;
  assign mValid        = valid;
  assign mData         = valid ? head[DATA_W-1:0] : '0;
  assign mPass_Last    = valid && head[DATA_W];
  assign mLast         = valid && head[DATA_W+1];
  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_weight_cache_reader.sv
// Randomised scoreboard bench for weight_cache_reader: a queue of expected beats
// built from the matrix/repeat arithmetic, drained by an independent monitor.
module tb_weight_cache_reader;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 20;
  localparam int CFG_W  = 16;
  localparam int W      = DATA_W + 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [CFG_W-1:0]  Matrix_Row = '0, Matrix_Col = '0, Repeat_Times = '0;
  logic              Cache_Rd_En;
  logic [ADDR_W-1:0] Cache_Rd_Addr;
  logic [DATA_W-1:0] Cache_Rd_Data = '0;
  logic [DATA_W-1:0] mData;
  logic              mValid, mReady = 1'b0, mPass_Last, mLast, busy, done;
  logic [1:0]        dbg_state;

  int errors = 0;
  int checks = 0;
  int ready_mode = 0;
  int pat = 0;
  logic [31:0] rd_cnt = '0;
  logic [W-1:0] exp_q[$];

  weight_cache_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CFG_W(CFG_W)) dut (
    .clk(clk), .reset(reset), .start(start),
    .Matrix_Row(Matrix_Row), .Matrix_Col(Matrix_Col), .Repeat_Times(Repeat_Times),
    .Cache_Rd_En(Cache_Rd_En), .Cache_Rd_Addr(Cache_Rd_Addr), .Cache_Rd_Data(Cache_Rd_Data),
    .mData(mData), .mValid(mValid), .mReady(mReady),
    .mPass_Last(mPass_Last), .mLast(mLast), .busy(busy), .done(done),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Cache RAM model: 1-cycle latency, word = {global read sequence number, address}.
  always @(posedge clk) begin
    if (Cache_Rd_En) begin
      Cache_Rd_Data <= {rd_cnt, 12'h0, Cache_Rd_Addr};
      rd_cnt        <= rd_cnt + 32'd1;
    end
  end

  task automatic check(input bit ok, input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // mReady driver: 0 = always, 1 = 1,0,0,1,0 pattern, 2 = random, 3 = never
  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       mReady = 1'b1;
      1:       mReady = (pat % 5 == 0) || (pat % 5 == 3);
      2:       mReady = ($urandom_range(0, 2) != 0);
      default: mReady = 1'b0;
    endcase
    pat++;
  end

  // monitor: pops the scoreboard on every handshake, checks stall stability
  initial begin
    logic         hold_v;
    logic [W-1:0] hold_w, got, e;
    hold_v = 1'b0;
    hold_w = '0;
    forever begin
      @(negedge clk);
      got = {mLast, mPass_Last, mData};
      if (reset) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v) check(mValid && (got == hold_w), "stall_stable", got, hold_w);
        if (mValid && mReady) begin
          if (exp_q.size() == 0) begin
            check(1'b0, "unexpected_beat", got, '0);
          end else begin
            e = exp_q.pop_front();
            check(got == e, "beat", got, e);
          end
        end
        hold_v = mValid && !mReady;
        hold_w = got;
      end
    end
  end

  task automatic run_job(input int row, input int col, input int rep, input int mode,
                         input bit dup);
    int wpp, n, budget;
    int rd_n, busy_n, done_rel, first_rd, first_v;
    bit degen;
    logic [31:0] base;
    logic [31:0] addr;
    rd_n = 0; busy_n = 0; done_rel = -1; first_rd = -1; first_v = -1;
    ready_mode   = mode;
    Matrix_Row   = CFG_W'(row);
    Matrix_Col   = CFG_W'(col);
    Repeat_Times = CFG_W'(rep);
    @(negedge clk);
    degen = (row == 0) || (col < 8) || (rep == 0);
    wpp   = row * (col / 8);
    n     = degen ? 0 : wpp * rep;
    base  = rd_cnt;
    for (int k = 0; k < n; k++) begin
      addr = 32'(k % wpp);
      exp_q.push_back({(k == n - 1), (addr == 32'(wpp - 1)), base + 32'(k), 12'h0,
                       addr[ADDR_W-1:0]});
    end
    start  = 1'b1;
    budget = n * 8 + 40;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start        = 1'b0;
        Matrix_Row   = CFG_W'($urandom);
        Matrix_Col   = CFG_W'($urandom);
        Repeat_Times = CFG_W'($urandom);
      end
      if (dup && c == 5) start = 1'b1;
      if (dup && c == 6) start = 1'b0;
      if (Cache_Rd_En) begin
        rd_n++;
        if (first_rd < 0) first_rd = c;
      end
      if (mValid && first_v < 0) first_v = c;
      if (busy) busy_n++;
      if (done) begin
        done_rel = c;
        break;
      end
    end
    check(done_rel > 0, "done_seen", W'(done_rel), W'(1));
    check(rd_n == n, "read_count", W'(rd_n), W'(n));
    check(busy_n == done_rel - 1, "busy_span", W'(busy_n), W'(done_rel - 1));
    if (degen) begin
      check(done_rel == 2, "degen_done_lat", W'(done_rel), W'(2));
      check(first_v < 0, "degen_no_valid", W'(first_v), W'(-1));
    end else if (mode == 0) begin
      check(first_rd == 1, "first_rd_cycle", W'(first_rd), W'(1));
      check(first_v == 2, "first_valid_cycle", W'(first_v), W'(2));
      check(done_rel == n + 3, "done_latency", W'(done_rel), W'(n + 3));
    end
    @(negedge clk);
    check(!done && !busy, "done_one_cycle", {done, busy}, '0);
    check(exp_q.size() == 0, "all_beats_seen", W'(exp_q.size()), '0);
    exp_q.delete();
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check({mValid, Cache_Rd_En, busy, done, mLast, mPass_Last} == '0, "reset_ctrl",
          {mValid, Cache_Rd_En, busy, done, mLast, mPass_Last}, '0);
    check(mData == '0 && Cache_Rd_Addr == '0, "reset_data", {mData, 2'b0}, '0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    run_job(2, 16, 2, 0, 1'b0);
    run_job(2, 16, 2, 1, 1'b0);
    run_job(2, 16, 2, 0, 1'b1);
    run_job(2, 4, 2, 0, 1'b0);
    run_job(2, 16, 0, 1, 1'b0);
    run_job(0, 16, 3, 0, 1'b0);

    // asynchronous reset while the buffer is full and stalled
    ready_mode   = 3;
    Matrix_Row   = 16'd2;
    Matrix_Col   = 16'd16;
    Repeat_Times = 16'd2;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check(mValid && busy, "stalled_before_reset", {mValid, busy}, 2'b11);
    #1 reset = 1'b1;
    #1;
    check({mValid, Cache_Rd_En, busy, mLast, mPass_Last} == '0 && mData == '0,
          "reset_mid_job", {mValid, Cache_Rd_En, busy, mData[3:0]}, '0);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    run_job(1, 8, 3, 0, 1'b0);

    run_job(64, 256, 1, 0, 1'b0);
    run_job(1, 8, 4, 2, 1'b0);
    for (int j = 0; j < 8; j++)
      run_job($urandom_range(1, 4), 8 * $urandom_range(1, 4), $urandom_range(1, 3), 2, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
